// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache miss-fill controller.
// No timing of its own; holds the FSM encoding, fill-target codes and block-base math.
// No flow control here; consumers own all handshakes.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic FILL_SEL_I = 1'b0;
    localparam logic FILL_SEL_D = 1'b1;

    // Block holds 2*words bytes, so the low log2(words)+1 address bits are the in-block offset.
    function automatic logic [31:0] block_base(input logic [31:0] addr, input logic [31:0] words);
        return addr & ~((words << 1) - 32'd1);
    endfunction

endpackage

// File: rtl/fill_counter.sv
// Up-counter with synchronous clear, count enable and terminal-count flag.
// Count updates one cycle after en; tc is combinational from the current count.
// No backpressure; the owner gates en.
module fill_counter #(
    parameter int W    = 4,
    parameter int TERM = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

    assign tc = (cnt == W'(TERM - 1));

endmodule

// File: rtl/cache_fill_ctrl.sv
// I/D-cache miss-fill controller: D-priority arbitration, block read issue, beat write-back, tag update.
// First fill_we MEM_LAT cycles after first mem_en; tag write WORDS_PER_BLOCK+MEM_LAT cycles after leaving IDLE.
// No memory backpressure (fixed-latency pipelined reads); requesters are held off via i_stall/d_stall. Option: FILL_CRITICAL_FIRST_EN.
module cache_fill_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MEM_LAT         = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_miss_req,
    input  logic [ADDR_W-1:0]                  i_miss_addr,
    input  logic                               d_miss_req,
    input  logic [ADDR_W-1:0]                  d_miss_addr,
    output logic                               mem_en,
    output logic [ADDR_W-1:0]                  mem_addr,
    input  logic                               mem_data_valid,
    input  logic [DATA_W-1:0]                  mem_data,
    output logic                               fill_we,
    output logic                               fill_sel,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word_idx,
    output logic [DATA_W-1:0]                  fill_data,
    output logic                               fill_tag_we,
    output logic [ADDR_W-1:0]                  fill_tag_addr,
    output logic                               i_stall,
    output logic                               d_stall,
    output logic                               busy
);

    localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] WPB_C = CNT_W'(WORDS_PER_BLOCK);

    if (MEM_LAT < 1 || WORDS_PER_BLOCK < 2 || ADDR_W > 32 ||
        (WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0) begin : g_bad_cfg
        $error("cache_fill_ctrl: unsupported parameter set");
    end

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   base_q;
    logic                sel_q;
    logic [IDX_W-1:0]    w0;
    logic [ADDR_W-1:0]   req_addr;
    logic                req_sel;
    logic                req_any;
    logic [CNT_W-1:0]    issue_cnt;
    logic                issue_tc;
    logic [CNT_W-1:0]    rx_cnt;
    logic                rx_tc;
    logic                beat_ok;
    logic [IDX_W-1:0]    issue_word;
    logic [IDX_W-1:0]    rx_word;
    logic [ADDR_W-1:0]   issue_off;

    assign req_any  = d_miss_req | i_miss_req;
    assign req_sel  = d_miss_req ? FILL_SEL_D : FILL_SEL_I;
    assign req_addr = d_miss_req ? d_miss_addr : i_miss_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q <= '0;
            sel_q  <= FILL_SEL_I;
        end else if (state_q == IDLE && req_any) begin
            base_q <= ADDR_W'(block_base(32'(req_addr), 32'(WORDS_PER_BLOCK)));
            sel_q  <= req_sel;
        end
    end

`ifdef FILL_CRITICAL_FIRST_EN
    logic [IDX_W-1:0] w0_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w0_q <= '0;
        end else if (state_q == IDLE && req_any) begin
            w0_q <= req_addr[IDX_W:1];
        end
    end

    assign w0 = w0_q;
`else
    assign w0 = '0;
`endif

    fill_counter #(.W(CNT_W), .TERM(WORDS_PER_BLOCK)) u_issue_cnt (
        .clk (clk),
        .rst (rst),
        .clr (state_q == IDLE),
        .en  (state_q == ISSUE),
        .cnt (issue_cnt),
        .tc  (issue_tc)
    );

    fill_counter #(.W(CNT_W), .TERM(WORDS_PER_BLOCK)) u_rx_cnt (
        .clk (clk),
        .rst (rst),
        .clr (state_q == IDLE),
        .en  (beat_ok),
        .cnt (rx_cnt),
        .tc  (rx_tc)
    );

    // Word indices wrap naturally in IDX_W bits because the block size is a power of two.
    assign issue_word = w0 + issue_cnt[IDX_W-1:0];
    assign rx_word    = w0 + rx_cnt[IDX_W-1:0];
    assign issue_off  = {{(ADDR_W-IDX_W-1){1'b0}}, issue_word, 1'b0};

    assign beat_ok = mem_data_valid && (state_q == ISSUE || state_q == DRAIN) && (rx_cnt < WPB_C);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        mem_en        = 1'b0;
        mem_addr      = '0;
        fill_we       = 1'b0;
        fill_word_idx = '0;
        fill_data     = '0;
        fill_tag_we   = 1'b0;
        fill_tag_addr = '0;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mem_en   = (issue_cnt < WPB_C);
                mem_addr = base_q + issue_off;
                if (issue_tc) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (beat_ok && rx_tc) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                fill_tag_we   = 1'b1;
                fill_tag_addr = base_q;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (beat_ok) begin
            fill_we       = 1'b1;
            fill_word_idx = rx_word;
            fill_data     = mem_data;
        end
    end

    assign busy     = (state_q != IDLE);
    assign fill_sel = busy ? sel_q : FILL_SEL_I;
    assign i_stall  = i_miss_req | (busy & (sel_q == FILL_SEL_I));
    assign d_stall  = d_miss_req | (busy & (sel_q == FILL_SEL_D));

    // Only WORDS_PER_BLOCK reads are ever issued, so any extra beat is a memory-side fault.
    a_no_extra_beats: assert property (@(posedge clk) disable iff (rst)
        !(mem_data_valid && (state_q == DONE ||
          ((state_q == ISSUE || state_q == DRAIN) && rx_cnt >= WPB_C))));

endmodule

// File: doc/cache_fill_ctrl.md
Name: cache_fill_ctrl

Overview:
- Parametrised miss-fill controller for the next-generation pipelined CPU, which adds I-cache and D-cache in front of a multi-cycle, pipelined main memory.
- Arbitrates between instruction-side and data-side miss requests and issues one block's worth of word reads to memory.
- Collects the returning beats, writes them into the selected cache's data array, then updates that cache's tag.
- Drives per-side stall outputs that the pipeline ORs into its global stall.

Parameters:
- ADDR_W, 16: byte address width.
- DATA_W, 16: memory word width.
- WORDS_PER_BLOCK, 8: words per cache block; power of two, at least 2.
- MEM_LAT, 4: cycles from mem_en to mem_data_valid for a read; at least 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- i_miss_req  in  1  I-cache miss; level, held until tag write.
- i_miss_addr  in  ADDR_W  I-side miss byte address.
- d_miss_req  in  1  D-cache miss; level, held until tag write.
- d_miss_addr  in  ADDR_W  D-side miss byte address.
- mem_en  out  1  memory read issue strobe.
- mem_addr  out  ADDR_W  memory read byte address.
- mem_data_valid  in  1  returned beat valid.
- mem_data  in  DATA_W  returned beat.
- fill_we  out  1  cache data-array write enable.
- fill_sel  out  1  fill target: 0 = I-cache, 1 = D-cache.
- fill_word_idx  out  log2(WORDS_PER_BLOCK)  word offset being written.
- fill_data  out  DATA_W  mem_data passed through.
- fill_tag_we  out  1  one-cycle tag/valid write for the filled block.
- fill_tag_addr  out  ADDR_W  block-aligned address of the fill.
- i_stall  out  1  I-side stall.
- d_stall  out  1  D-side stall.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. All outputs reset to 0; state = IDLE; counters = 0.
- Block size and base address: block bytes = 2*WORDS_PER_BLOCK. Base = miss address with the low log2(WORDS_PER_BLOCK)+1 bits cleared.
- IDLE:
  - If d_miss_req is high, latch d_miss_addr and set sel=1. Otherwise, if i_miss_req is high, latch i_miss_addr and set sel=0. D has fixed priority.
  - Go to ISSUE on the next edge.
  - mem_data_valid is ignored in IDLE.
- ISSUE:
  - mem_en=1 for exactly WORDS_PER_BLOCK consecutive cycles.
  - mem_addr = base + 2*issue_cnt; issue_cnt increments each cycle.
  - After the last issue, go to DRAIN.
- ISSUE/DRAIN beat handling:
  - Each mem_data_valid produces, combinationally in the same cycle: fill_we=1, fill_data=mem_data, fill_word_idx=rx order index, fill_sel=sel.
  - rx_cnt then increments.
- Last beat (rx_cnt = WORDS_PER_BLOCK-1 with valid):
  - Go to DONE.
- DONE (one cycle):
  - fill_tag_we=1 and fill_tag_addr=base.
  - Go to IDLE.
  - A still-pending other side is accepted in the following IDLE cycle, so there is at least one IDLE cycle between fills.
- Latency: first fill_we occurs MEM_LAT cycles after the first mem_en. fill_tag_we occurs WORDS_PER_BLOCK+MEM_LAT cycles after leaving IDLE.
- Stalls:
  - i_stall = i_miss_req, or (busy and sel=0).
  - d_stall = d_miss_req, or (busy and sel=1).
  - A side waiting behind the other side's fill stays stalled.
- Request dropped mid-fill (e.g. branch flush of the I-side): the fill still completes and the tag is written; no abort.
- Beats beyond WORDS_PER_BLOCK in DRAIN: not written, flagged by assertion.
- Reset mid-fill: immediate return to IDLE. Beats arriving after reset are ignored (IDLE).
- Counter width: log2(WORDS_PER_BLOCK)+1 bits; compare against WORDS_PER_BLOCK explicitly, with no reliance on wrap.

Optional Feature:
- Macro: FILL_CRITICAL_FIRST_EN.
- Defined:
  - Issue order starts at the missed word w0 = miss_addr[log2(WPB):1] and wraps modulo WORDS_PER_BLOCK.
  - mem_addr = base + 2*((w0+issue_cnt) mod WPB).
  - fill_word_idx = (w0+rx_cnt) mod WPB.
- Undefined: w0 forced to 0, giving sequential order from word 0.
- All other timing is identical in both builds.

Decomposition:
- Package cache_pkg holds:
  - state enum {IDLE, ISSUE, DRAIN, DONE};
  - FILL_SEL_I=0 and FILL_SEL_D=1;
  - a function computing the block base from an address.
- One sub-module, fill_counter: a parametrised up-counter with clear, enable and terminal-count output, instantiated twice (issue_cnt, rx_cnt).

Test Plan:
- Sequential fill: WPB=8, LAT=4, i_miss_req with addr 0x0046 -> mem_addr 0x0040..0x004E over 8 cycles; fill_we words 0..7 at cycles 5..12; fill_tag_we with tag addr 0x0040 at cycle 13; i_stall high throughout.
- Simultaneous misses: I 0x0100 and D 0x2012 in the same cycle -> D block 0x2010 filled first; i_stall held; I fill starts one IDLE cycle after D's tag write.
- Critical-first with FILL_CRITICAL_FIRST_EN: addr 0x004C -> issue words 6,7,0,1..5; fill_word_idx follows 6,7,0..5.
- Reset mid-fill: assert rst during the 4th beat -> outputs 0 next cycle; trailing valids produce no fill_we.
- I request dropped mid-fill: i_miss_req falls during ISSUE -> fill still completes and fill_tag_we pulses.
- Idle noise: mem_data_valid pulsed in IDLE -> no fill_we and busy stays 0.
